// File: rtl/counter_sequencer.sv
// Command-driven WIDTH-bit up/down counter controller: accepts CLEAR/UP/DOWN/BOUNCE
// jobs over valid/ready, steps the embedded counter and pulses done (and aborted) at job end.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock_signal,
    input  logic             reset_signal,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_UP    = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_BOUNCE = 2'b11;

    logic [2:0]       state_reg,     state_next;
    logic [WIDTH-1:0] count_reg,     count_next;
    logic             up_down_reg,   up_down_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0] peak_reg,      peak_next;
    logic             bounce_reg,    bounce_next;
    logic             aborted_reg,   aborted_next;

    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign count_inc = count_reg + WIDTH'(1);
    assign count_dec = count_reg - WIDTH'(1);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        up_down_next   = up_down_reg;
        remaining_next = remaining_reg;
        peak_next      = peak_reg;
        bounce_next    = bounce_reg;
        aborted_next   = aborted_reg;

        case (state_reg)
            S_IDLE: begin
                aborted_next = 1'b0;
                if (cmd_valid) begin
                    remaining_next = cmd_len;
                    peak_next      = cmd_len;
                    bounce_next    = (cmd_op == OP_BOUNCE);
                    case (cmd_op)
                        OP_CLEAR: state_next = S_CLEAR;
                        OP_UP: begin
                            if (cmd_len == '0) begin
                                state_next = S_DONE;
                            end else begin
                                state_next   = S_UP;
                                up_down_next = 1'b1;
                            end
                        end
                        OP_DOWN: begin
                            if (cmd_len == '0) begin
                                state_next = S_DONE;
                            end else begin
                                state_next   = S_DOWN;
                                up_down_next = 1'b0;
                            end
                        end
                        default: begin
                            // Bounce peak is absolute: already at/above it means descend immediately.
                            if (cmd_len == '0) begin
                                state_next = S_DONE;
                            end else if (count_reg >= cmd_len) begin
                                state_next   = S_DOWN;
                                up_down_next = 1'b0;
                            end else begin
                                state_next   = S_UP;
                                up_down_next = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_CLEAR: begin
                state_next = S_DONE;
                if (abort) begin
                    aborted_next = 1'b1;
                end else begin
                    count_next = '0;
                end
            end
            S_UP: begin
                if (abort) begin
                    state_next   = S_DONE;
                    aborted_next = 1'b1;
                end else if (!pause) begin
                    count_next     = count_inc;
                    up_down_next   = 1'b1;
                    remaining_next = remaining_reg - WIDTH'(1);
                    if (bounce_reg) begin
                        if (count_inc == peak_reg) begin
                            state_next = S_DOWN;
                        end
                    end else if (remaining_reg == WIDTH'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_next   = S_DONE;
                    aborted_next = 1'b1;
                end else if (!pause) begin
                    count_next     = count_dec;
                    up_down_next   = 1'b0;
                    remaining_next = remaining_reg - WIDTH'(1);
                    if (bounce_reg) begin
                        if (count_dec == '0) begin
                            state_next = S_DONE;
                        end
                    end else if (remaining_reg == WIDTH'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            up_down_reg   <= 1'b0;
            remaining_reg <= '0;
            peak_reg      <= '0;
            bounce_reg    <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            up_down_reg   <= up_down_next;
            remaining_reg <= remaining_next;
            peak_reg      <= peak_next;
            bounce_reg    <= bounce_next;
            aborted_reg   <= aborted_next;
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg == S_CLEAR) || (state_reg == S_UP) || (state_reg == S_DOWN);
    assign done      = (state_reg == S_DONE);
    assign aborted   = (state_reg == S_DONE) && aborted_reg;
    assign count     = count_reg;
    assign up_down   = up_down_reg;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller for a WIDTH-bit up/down counter; the counter datapath is embedded in this block.
- It accepts counting jobs over a valid/ready handshake and sequences the counter's enable, direction and clear.
- It reports progress and pulses done when a job finishes.
- Sits between a host FSM/CPU-side register block and any logic consuming the count (timers, display drivers).

Parameters:
- WIDTH, 4, counter and length width in bits.

Ports:
- clock_signal  input  1  system clock; all state changes on the rising edge.
- reset_signal  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 CLEAR, 01 UP, 10 DOWN, 11 BOUNCE.
- cmd_len  input  WIDTH  number of steps, or bounce peak.
- pause  input  1  hold the count while high.
- abort  input  1  terminate the current job.
- count  output  WIDTH  counter value.
- up_down  output  1  current direction: 1 = up, 0 = down.
- busy  output  1  a job is in progress.
- done  output  1  one-cycle pulse at the end of a job.
- aborted  output  1  one-cycle pulse, coincident with done, when the job ended by abort.

Behaviour:
- Reset (reset_signal low, asynchronous):
  - count=0, up_down=0, busy=0, done=0, aborted=0, cmd_ready=1, state=IDLE.
  - The outputs hold these values while reset is low.
- Handshake:
  - A command is accepted on a cycle where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE); it is 0 for the whole job, including the DONE cycle.
  - cmd_op and cmd_len are captured at acceptance; later input changes are ignored.
- States: IDLE, CLEAR, UP, DOWN, DONE.
- IDLE:
  - count holds its value.
  - On acceptance, next state by opcode: CLEAR→CLEAR; UP→UP; DOWN→DOWN; BOUNCE→UP with the bounce flag set.
  - busy goes to 1 from the cycle after acceptance.
  - A len of 0 for UP, DOWN or BOUNCE goes directly to DONE; count is unchanged.
- CLEAR: count←0 in one cycle, then DONE. pause is ignored.
- UP:
  - up_down=1.
  - Each non-paused cycle: count←count+1, modulo 2^WIDTH (15→0 at WIDTH=4), and the remaining-step counter decrements.
  - Plain UP: after len steps, go to DONE.
  - BOUNCE: count is treated as absolute. Increment until count==len, then go to DOWN.
  - If count is already ≥len at BOUNCE acceptance, skip directly to DOWN.
- DOWN:
  - up_down=0.
  - Each non-paused cycle: count←count−1, modulo 2^WIDTH (0→15).
  - Plain DOWN: after len steps, go to DONE.
  - BOUNCE: decrement until count==0, then go to DONE. No wrap in bounce.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0.
  - Then IDLE; cmd_ready=1 on the following cycle.
- Latency: a plain UP/DOWN job of len L with no pause has its first count change the cycle after acceptance and done L+1 cycles after acceptance.
- pause:
  - Sampled each cycle in UP/DOWN; when high, count and the step counter hold.
  - Has no effect in IDLE, CLEAR or DONE.
- abort:
  - Sampled in CLEAR/UP/DOWN; next state is DONE with aborted=1.
  - count keeps its value from the abort cycle (no step taken that cycle).
  - abort has priority over pause and over a normal completion in the same cycle.
  - abort in IDLE is ignored.
- up_down holds its last value in IDLE/DONE/CLEAR.
- Simultaneous cmd_valid in DONE is not accepted (cmd_ready=0); it is accepted in the next IDLE cycle.
- Reset mid-job: immediate return to the reset values; the job is discarded and no done pulse is issued.

Test Plan:
- Reset then UP len=5 from 0, no pause → count 1,2,3,4,5 on the 5 cycles after acceptance; done pulses once with count=5; cmd_ready returns high the cycle after done.
- From count=14, UP len=3 → 15,0,1 (wrap); then DOWN len=2 → 0,15; up_down 1 then 0; done after each job.
- BOUNCE len=3 from count=0 → 1,2,3,2,1,0; up_down 1,1,1,0,0,0; a single done with count=0.
- UP len=6 with pause high for 3 cycles mid-job → count holds 3 cycles; done arrives 3 cycles later than the unpaused case; final count=6.
- DOWN len=8 from 10, abort asserted on the 3rd step cycle together with pause → count stops at 8; done=aborted=1 for one cycle; the next command is accepted.
- reset_signal pulsed low asynchronously mid-BOUNCE (between clock edges) → count=0, busy=0, cmd_ready=1 immediately with no done pulse; a CLEAR command afterwards gives done after 2 cycles.
